chan_pkt_framer: RTL
====================

CHAN_PKT_FRAMER -- requirements
Module: chan_pkt_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the sample width (packed 16-bit I/Q).
REQ-002 SHALL have parameter BIN_WIDTH, default 12, giving the FFT bin index width on tuser.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port payload_length, input, 16, packet payload size in bytes.
REQ-006 SHALL have port eob_req, input, 1, single-cycle request to end the burst.
REQ-007 SHALL have port s_axis_tdata, input, DATA_WIDTH, channelizer output sample.
REQ-008 SHALL have port s_axis_tuser, input, BIN_WIDTH, FFT bin index of the sample.
REQ-009 SHALL have ports s_axis_tvalid (input, 1) and s_axis_tready (output, 1).
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH, framed sample.
REQ-011 SHALL have port m_axis_tuser, output, BIN_WIDTH, bin index passed through with its sample.
REQ-012 SHALL have ports m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1).
REQ-013 SHALL have port eob_tag, output, 1, asserted with tlast on the final packet of a burst.

Function
REQ-014 SHALL implement states SYNC and RUN.
REQ-015 In SYNC: s_axis_tready=1 and input beats are discarded until a beat with s_axis_tuser==0 is accepted. That beat SHALL be forwarded as packet sample 0, and the block SHALL enter RUN.
REQ-016 In RUN: every accepted input beat SHALL be forwarded unmodified, in order, with no loss or duplication.
REQ-017 At packet start (sample 0), the packet length SHALL be latched as N = payload_length[15:2]; N==0 is treated as N=1.
REQ-018 A change to payload_length mid-packet SHALL take effect only at the next packet.
REQ-019 A sample counter SHALL count 0..N-1. The beat at count N-1 carries m_axis_tlast=1, and the counter wraps to 0 with no gap cycle.
REQ-020 eob_req SHALL set a sticky eob_pending flag. eob_req and an accepted tlast beat in the same cycle SHALL count as pending for that packet.
REQ-021 The tlast beat emitted while eob_pending=1 SHALL carry eob_tag=1. After it, eob_pending SHALL clear and the state SHALL return to SYNC.
REQ-022 eob_tag SHALL be 0 on every beat that does not carry tlast.
REQ-023 An eob_req received in SYNC SHALL stay pending and apply to the first packet after resync.
REQ-024 Output SHALL be fully registered with a 2-entry skid buffer.
REQ-025 s_axis_tready SHALL depend only on registered state, never combinationally on m_axis_tready.
REQ-026 Latency SHALL be 1 cycle from input acceptance to m_axis_tvalid.
REQ-027 Sustained throughput SHALL be 1 beat/cycle while m_axis_tready=1.
REQ-028 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* and eob_tag SHALL hold stable.
REQ-029 A beat is transferred only when tvalid and tready are both high, on either port.
REQ-030 When the skid buffer is full, s_axis_tready SHALL be 0; no beat is dropped in RUN.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately force: state=SYNC, counter=0, eob_pending=0, skid buffer empty.
REQ-032 During reset: m_axis_tvalid=0, m_axis_tlast=0, eob_tag=0 and s_axis_tready=0.
REQ-033 m_axis_tdata and m_axis_tuser SHALL reset to 0.
REQ-034 After reset_n deasserts, s_axis_tready SHALL rise on the first clock edge.
REQ-035 Reset mid-packet SHALL discard the partial packet; no tlast is emitted for it.

Verification
REQ-036 Resync: payload_length=16, input bins 5,6,7,0,1,2,3,0... -> bins 5..7 dropped; output starts at bin 0; tlast on every 4th output beat.
REQ-037 Backpressure: m_axis_tready toggles randomly 50% over 1000 beats, N=8 -> output sequence equals input sequence; tlast exactly at beats 8k-1; no data change while stalled.
REQ-038 Length change: payload_length 32 -> 8 written at sample 3 of a packet -> that packet is 8 beats; following packets are 2 beats.
REQ-039 EOB: eob_req pulsed mid-packet with N=4 -> that packet's tlast beat has eob_tag=1. The next input beats are dropped until bin 0, and the next packet has eob_tag=0.
REQ-040 Edge cases: payload_length=0 or 3 gives tlast on every beat; eob_req coincident with an accepted tlast tags that packet.
REQ-041 Reset mid-packet: reset_n low for 1 cycle at sample 5 of 8 -> m_axis_tvalid drops immediately; after release, output resumes only at the next bin 0, counting from 0.

Source files
------------

// File: rtl/chan_pkt_framer.sv
// Channelizer packet framer: aligns to FFT bin 0, cuts fixed-length packets,
// tags the final packet of a burst, and drives the output from a 2-entry skid buffer.
module chan_pkt_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           payload_length,
    input  logic                  eob_req,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [BIN_WIDTH-1:0]  s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BIN_WIDTH-1:0]  m_axis_tuser,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  eob_tag
);

    typedef enum logic {SYNC, RUN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [BIN_WIDTH-1:0]  user;
        logic                  last;
        logic                  eob;
    } beat_t;

    state_t      r_state, w_state_nx;
    logic [13:0] r_cnt, w_cnt_nx;
    logic [13:0] r_len, w_len_nx;
    logic        r_pend, w_pend_nx;
    logic        r_rdy, r_vld;
    logic [1:0]  r_fill, w_fill_nx;
    beat_t       r_buf0, r_buf1, w_buf0_nx, w_buf1_nx, w_new;

    logic        w_acc, w_pop, w_fwd, w_last, w_eob, w_slot;
    logic [13:0] w_plen, w_nnew, w_idx, w_n;

    assign w_acc  = s_axis_tvalid & r_rdy;
    assign w_pop  = r_vld & m_axis_tready;
    assign w_fwd  = w_acc & ((r_state == RUN) | (s_axis_tuser == '0));
    assign w_plen = payload_length[15:2];
    assign w_nnew = (w_plen == 14'd0) ? 14'd1 : w_plen;
    assign w_idx  = (r_state == SYNC) ? 14'd0 : r_cnt;
    // Length is sampled only on sample 0 so mid-packet changes wait a packet
    assign w_n    = (w_idx == 14'd0) ? w_nnew : r_len;
    assign w_last = (w_idx == w_n - 14'd1);
    assign w_eob  = r_pend | eob_req;
    assign w_new  = '{data: s_axis_tdata, user: s_axis_tuser,
                      last: w_last, eob: w_last & w_eob};

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_len_nx   = r_len;
        w_pend_nx  = w_eob;
        if (w_fwd) begin
            w_len_nx = w_n;
            if (w_last) begin
                w_cnt_nx   = 14'd0;
                w_pend_nx  = 1'b0;
                w_state_nx = w_eob ? SYNC : RUN;
            end else begin
                w_cnt_nx   = w_idx + 14'd1;
                w_state_nx = RUN;
            end
        end
    end

    // Slot for the incoming beat is the occupancy left after this cycle's pop
    assign w_slot = ((r_fill - {1'b0, w_pop}) != 2'd0);

    always_comb begin
        w_buf0_nx = r_buf0;
        w_buf1_nx = r_buf1;
        w_fill_nx = r_fill - {1'b0, w_pop} + {1'b0, w_fwd};
        if (w_pop && r_fill == 2'd2) begin
            w_buf0_nx = r_buf1;
        end
        if (w_fwd) begin
            if (w_slot) begin
                w_buf1_nx = w_new;
            end else begin
                w_buf0_nx = w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SYNC;
            r_cnt   <= '0;
            r_len   <= 14'd1;
            r_pend  <= 1'b0;
            r_fill  <= '0;
            r_rdy   <= 1'b0;
            r_vld   <= 1'b0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_len   <= w_len_nx;
            r_pend  <= w_pend_nx;
            r_fill  <= w_fill_nx;
            r_rdy   <= (w_fill_nx != 2'd2);
            r_vld   <= (w_fill_nx != 2'd0);
            r_buf0  <= w_buf0_nx;
            r_buf1  <= w_buf1_nx;
        end
    end

    assign s_axis_tready = r_rdy;
    assign m_axis_tvalid = r_vld;
    assign m_axis_tdata  = r_buf0.data;
    assign m_axis_tuser  = r_buf0.user;
    assign m_axis_tlast  = r_buf0.last;
    assign eob_tag       = r_buf0.eob;

endmodule
